mb_word_reader: RTL and testbench

Upstream feeder for the macroblock fetch stage. On a start command it computes the macroblock's base word address, issues 96 pipelined word reads to the frame memory port (64 Y words, then 16 U, then 16 V), and forwards the returned words in order to the fetch stage as `data_word_o`/`data_valid_o`. It also generates the fetch stage's start pulse, so fetch is already in its Y-load state when the first word arrives.

---
 rtl/mb_word_reader.sv | 171 +++++++++++++++++
 tb/tb_mb_word_reader.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mb_word_reader.sv
// mb_word_reader
// ---------------------------------------------------------------------------
// Upstream feeder for the macroblock fetch stage. A start request latches the
// macroblock coordinates, computes the base word address and issues MB_WORDS
// pipelined word reads (Y, then U, then V) to the frame memory port, keeping at
// most MAX_OUT reads outstanding. Returned words are forwarded in order to the
// fetch stage one register stage after the memory returns them. A one-cycle
// fetch_start_o pulse is raised with the first request so the fetch stage is
// already waiting when the first word arrives.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start_i         start request, sampled only while idle
//   mb_x_i, mb_y_i  macroblock column / row, latched on accept
//   busy_o          transfer in progress (including the done_o cycle)
//   done_o          one-cycle pulse with the last data_valid_o
//   fetch_start_o   one-cycle start pulse to the fetch stage
//   mem_req_o       read request valid
//   mem_addr_o      read word address, held while a request waits for a grant
//   mem_gnt_i       request accepted this cycle
//   mem_rvalid_i    read data valid (in-order responses)
//   mem_rdata_i     read data
//   data_word_o     forwarded word (byte 0 is the leftmost pixel)
//   data_valid_o    data_word_o valid, no backpressure
// ---------------------------------------------------------------------------
module mb_word_reader #(
  parameter int ROW_MB_NUM = 22,
  parameter int MB_WORDS   = 96,
  parameter int MAX_OUT    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [5:0]  mb_x_i,
  input  logic [5:0]  mb_y_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fetch_start_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] data_word_o,
  output logic        data_valid_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam logic [6:0] LAST_WORD = 7'(MB_WORDS - 1);
  localparam logic [3:0] OUT_LIMIT = 4'(MAX_OUT);

  state_t      state;
  logic [6:0]  issued;
  logic [6:0]  received;
  logic [3:0]  outstanding;

  logic        grant;
  logic        accept_rsp;
  logic        last_grant;
  logic        last_rsp;
  logic [3:0]  outstanding_nxt;
  logic [31:0] base_calc;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant      = mem_req_o & mem_gnt_i;
    // A response with nothing outstanding is stale (e.g. issued before a
    // reset) and must not be forwarded or counted.
    accept_rsp = mem_rvalid_i & (outstanding != 4'd0);
    last_grant = grant & (issued == LAST_WORD);
    last_rsp   = accept_rsp & (received == LAST_WORD);

    outstanding_nxt = outstanding;
    if (grant && !accept_rsp) begin
      outstanding_nxt = outstanding + 4'd1;
    end else if (!grant && accept_rsp) begin
      outstanding_nxt = outstanding - 4'd1;
    end

    // 32-bit unsigned, wraps silently.
    base_calc = (32'(mb_y_i) * 32'(ROW_MB_NUM) + 32'(mb_x_i)) * 32'(MB_WORDS);
  end

  // All outputs are registers. mem_req_o is computed from the next-cycle
  // outstanding count, so a slot freed by a response is usable one cycle
  // later, and mem_addr_o steps by one on every grant.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      issued        <= '0;
      received      <= '0;
      outstanding   <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      fetch_start_o <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= '0;
      data_word_o   <= '0;
      data_valid_o  <= 1'b0;
    end else begin
      fetch_start_o <= 1'b0;
      done_o        <= 1'b0;
      data_valid_o  <= accept_rsp;
      if (accept_rsp) begin
        data_word_o <= mem_rdata_i;
      end

      case (state)
        IDLE: begin
          mem_req_o <= 1'b0;
          if (start_i) begin
            state         <= ISSUE;
            issued        <= '0;
            received      <= '0;
            outstanding   <= '0;
            busy_o        <= 1'b1;
            fetch_start_o <= 1'b1;
            mem_req_o     <= 1'b1;
            mem_addr_o    <= base_calc;
          end else begin
            // busy_o stays high through the done_o cycle and drops here.
            busy_o <= 1'b0;
          end
        end

        ISSUE: begin
          outstanding <= outstanding_nxt;
          if (grant) begin
            issued     <= issued + 7'd1;
            mem_addr_o <= mem_addr_o + 32'd1;
          end
          if (accept_rsp) begin
            received <= received + 7'd1;
          end
          if (last_grant) begin
            state     <= DRAIN;
            mem_req_o <= 1'b0;
          end else begin
            mem_req_o <= (outstanding_nxt < OUT_LIMIT);
          end
        end

        DRAIN: begin
          mem_req_o   <= 1'b0;
          outstanding <= outstanding_nxt;
          if (accept_rsp) begin
            received <= received + 7'd1;
          end
          if (last_rsp) begin
            state  <= IDLE;
            done_o <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mb_word_reader.sv
// tb_mb_word_reader
// ---------------------------------------------------------------------------
// Drives mb_word_reader against a behavioural frame memory (random grants,
// random or fixed in-order latency, rdata = word address) and compares every
// cycle with a reference model built from the transfer rules: outstanding is
// grants minus accepted responses, addresses are base + words granted, words
// are delivered one cycle after their accepted response.
// ---------------------------------------------------------------------------
module tb_mb_word_reader;

  localparam int ROW_MB_NUM = 22;
  localparam int MB_WORDS   = 96;
  localparam int MAX_OUT    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  mb_x_i;
  logic [5:0]  mb_y_i;
  logic        busy_o;
  logic        done_o;
  logic        fetch_start_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] data_word_o;
  logic        data_valid_o;

  always #5 clk = ~clk;

  mb_word_reader #(
    .ROW_MB_NUM(ROW_MB_NUM),
    .MB_WORDS  (MB_WORDS),
    .MAX_OUT   (MAX_OUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .mb_x_i       (mb_x_i),
    .mb_y_i       (mb_y_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fetch_start_o(fetch_start_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .data_word_o  (data_word_o),
    .data_valid_o (data_valid_o)
  );

  int n_asserts = 0;
  int n_fails   = 0;
  int cyc       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural memory: in-order responses, each at least one cycle after its grant.
  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  rsp_t pend[$];
  int   lat_min = 1;
  int   lat_max = 1;
  int   gnt_pct = 100;
  int   last_due = 0;
  int   stall_word [2] = '{-1, -1};
  int   stall_left [2] = '{0, 0};
  bit   inject_spurious = 1'b0;

  // Reference model of the transfer.
  bit          active = 1'b0;
  int          n_g = 0;
  int          n_r = 0;
  logic [31:0] base_ref = '0;
  bit          exp_dv = 1'b0;
  bit          exp_done = 1'b0;
  bit          exp_fetch = 1'b0;
  bit          exp_busy = 1'b0;
  logic [31:0] exp_word = '0;
  bit          rst_prev = 1'b0;

  // Observations gathered per test.
  int accept_cyc = 0;
  int obs_done_cyc = 0;
  int obs_words = 0;
  int done_obs = 0;
  int max_outst = 0;
  bit limit_hit = 1'b0;

  task automatic begin_test();
    obs_words = 0;
    done_obs  = 0;
    max_outst = 0;
    limit_hit = 1'b0;
  endtask

  // One clock cycle: check outputs at the falling edge, drive inputs for this
  // cycle, then advance the model across the rising edge.
  task automatic step(input bit do_rst, input bit do_start, input logic [5:0] x, input logic [5:0] y);
    bit          req_s;
    bit          fire;
    bit          acc;
    bit          idle_now;
    logic [31:0] addr_s;
    int          outst;
    int          lat;
    int          due;
    rsp_t        r;

    @(negedge clk);
    outst = n_g - n_r;
    check("busy", 32'(busy_o), 32'(exp_busy));
    check("fetch_start", 32'(fetch_start_o), 32'(exp_fetch));
    check("data_valid", 32'(data_valid_o), 32'(exp_dv));
    check("data_word", data_word_o, exp_word);
    check("done", 32'(done_o), 32'(exp_done));
    check("mem_req", 32'(mem_req_o), 32'(active && n_g < MB_WORDS && outst < MAX_OUT));
    if (mem_req_o === 1'b1) check("mem_addr", mem_addr_o, base_ref + 32'(n_g));
    if (rst_prev) check("mem_addr_after_rst", mem_addr_o, 32'd0);
    if (data_valid_o === 1'b1) obs_words++;
    if (done_o === 1'b1) begin
      done_obs++;
      obs_done_cyc = cyc;
    end
    if (active && n_g < MB_WORDS && outst == MAX_OUT) limit_hit = 1'b1;
    if (outst > max_outst) max_outst = outst;

    rst     = do_rst;
    start_i = do_start;
    mb_x_i  = x;
    mb_y_i  = y;
    mem_gnt_i = (int'($urandom_range(1, 100)) <= gnt_pct);
    for (int s = 0; s < 2; s++) begin
      if (mem_req_o === 1'b1 && n_g == stall_word[s] && stall_left[s] > 0) begin
        mem_gnt_i = 1'b0;
        stall_left[s]--;
      end
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = $urandom;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = r.data;
    end else if (inject_spurious && pend.size() == 0) begin
      mem_rvalid_i    = 1'b1;
      inject_spurious = 1'b0;
    end
    req_s  = (mem_req_o === 1'b1);
    addr_s = mem_addr_o;

    @(posedge clk);
    fire = req_s && mem_gnt_i;
    if (fire) begin
      lat = int'($urandom_range(lat_min, lat_max));
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{due: due, data: addr_s});
    end

    idle_now  = !active;
    acc       = mem_rvalid_i && (outst != 0);
    exp_fetch = 1'b0;
    exp_done  = 1'b0;
    if (do_rst) begin
      active   = 1'b0;
      n_g      = 0;
      n_r      = 0;
      exp_dv   = 1'b0;
      exp_word = '0;
      exp_busy = 1'b0;
    end else begin
      exp_dv = acc;
      if (acc) begin
        exp_word = base_ref + 32'(n_r);
        n_r++;
        if (n_r == MB_WORDS) begin
          exp_done = 1'b1;
          active   = 1'b0;
        end
      end
      if (fire) n_g++;
      if (idle_now && do_start) begin
        active     = 1'b1;
        n_g        = 0;
        n_r        = 0;
        base_ref   = (32'(y) * 32'(ROW_MB_NUM) + 32'(x)) * 32'(MB_WORDS);
        exp_fetch  = 1'b1;
        accept_cyc = cyc;
      end
      exp_busy = active || exp_done;
    end
    rst_prev = do_rst;
    cyc++;
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int n = 0;
    while ((active || exp_busy || pend.size() != 0) && n < budget) begin
      step(1'b0, 1'b0, 6'd0, 6'd0);
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;

    rst = 1'b1;
    start_i = 1'b0;
    mb_x_i = '0;
    mb_y_i = '0;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    step(1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b1, 1'b0, 6'd0, 6'd0);
    step(1'b0, 1'b0, 6'd0, 6'd0);

    // Basic fetch: mb (2,1), zero-wait grants, latency 1.
    begin_test();
    step(1'b0, 1'b1, 6'd2, 6'd1);
    check("basic_base", base_ref, 32'd2304);
    run_until_idle("basic_timeout", 400);
    check("basic_words", 32'(obs_words), 32'd96);
    check("basic_done_latency", 32'(obs_done_cyc - accept_cyc), 32'd98);
    check("basic_done_count", 32'(done_obs), 32'd1);

    // Grant stalls of 3 cycles at words 10 and 70.
    begin_test();
    stall_word = '{10, 70};
    stall_left = '{3, 3};
    step(1'b0, 1'b1, 6'd5, 6'd3);
    run_until_idle("stall_timeout", 400);
    check("stall_a_used", 32'(stall_left[0]), 32'd0);
    check("stall_b_used", 32'(stall_left[1]), 32'd0);
    check("stall_words", 32'(obs_words), 32'd96);
    stall_word = '{-1, -1};

    // Outstanding limit with latency 8.
    begin_test();
    lat_min = 8;
    lat_max = 8;
    step(1'b0, 1'b1, 6'd21, 6'd17);
    run_until_idle("limit_timeout", 1000);
    check("limit_reached", 32'(limit_hit), 32'd1);
    check("limit_not_exceeded", 32'(max_outst <= MAX_OUT), 32'd1);
    check("limit_words", 32'(obs_words), 32'd96);

    // Start while busy (random grants and latency), then a spurious rvalid in IDLE.
    begin_test();
    lat_min = 1;
    lat_max = 4;
    gnt_pct = 70;
    step(1'b0, 1'b1, 6'd7, 6'd2);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 6'($urandom), 6'($urandom));
    run_until_idle("busy_timeout", 1500);
    check("busy_words", 32'(obs_words), 32'd96);
    check("busy_done_count", 32'(done_obs), 32'd1);
    inject_spurious = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 6'd0, 6'd0);
    check("spurious_consumed", 32'(inject_spurious), 32'd0);
    check("spurious_no_word", 32'(obs_words), 32'd96);

    // Reset at word 40 with 3 reads in flight, then mb (0,0).
    begin_test();
    lat_min = 3;
    lat_max = 3;
    gnt_pct = 100;
    step(1'b0, 1'b1, 6'd9, 6'd1);
    n = 0;
    while (n_r < 40 && n < 300) begin
      step(1'b0, 1'b0, 6'd0, 6'd0);
      n++;
    end
    check("rst_reach_word40", 32'(n < 300), 32'd1);
    check("rst_inflight", 32'(pend.size()), 32'd3);
    step(1'b1, 1'b0, 6'd0, 6'd0);
    begin_test();
    run_until_idle("rst_drain_timeout", 50);
    check("rst_late_dropped", 32'(obs_words), 32'd0);
    lat_min = 1;
    lat_max = 1;
    step(1'b0, 1'b1, 6'd0, 6'd0);
    check("rst_new_base", base_ref, 32'd0);
    run_until_idle("rst_new_timeout", 400);
    check("rst_new_words", 32'(obs_words), 32'd96);

    // Back-to-back: second start in the cycle after done_o.
    begin_test();
    step(1'b0, 1'b1, 6'd3, 6'd4);
    n = 0;
    while (!exp_done && n < 400) begin
      step(1'b0, 1'b0, 6'd0, 6'd0);
      n++;
    end
    check("b2b_first_done", 32'(n < 400), 32'd1);
    step(1'b0, 1'b0, 6'd0, 6'd0);
    step(1'b0, 1'b1, 6'd10, 6'd0);
    check("b2b_second_base", base_ref, 32'd960);
    run_until_idle("b2b_timeout", 400);
    check("b2b_done_count", 32'(done_obs), 32'd2);
    check("b2b_words", 32'(obs_words), 32'd192);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
